// File: rtl/ee354_project_move_sched.sv
`default_nettype none
// =============================================================================
// ee354_project_move_sched : tick-paced snake step scheduler with 2-deep direction queue
// Rev 1.0
// =============================================================================
module ee354_project_move_sched #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int MIN_DIV    = 6_250_000,
  parameter int SPEED_STEP = 1_000_000,
  parameter int CNT_W      = 25
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             q_Run,
  input  logic             SCEN_dir,
  input  logic [1:0]       In_Dirn,
  input  logic             Step_Done,
  input  logic             Collision,
  input  logic             Ate_Apple,
  input  logic             Apple_Ready,
  output logic             Step_Req,
  output logic [1:0]       Cur_Dirn,
  output logic             New_Apple,
  output logic             Hit,
  output logic [CNT_W-1:0] Tick_Period,
  output logic             Busy
);

  localparam logic [CNT_W-1:0] TICK_INIT = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] STEP_P    = CNT_W'(SPEED_STEP);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W:0]   SAT_EDGE  = (CNT_W + 1)'(MIN_DIV + SPEED_STEP);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    STEP      = 3'd2,
    APPLE     = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sped_period;

  logic [1:0] q0, q1;
  logic [1:0] q_cnt;
  logic       pop, push, dir_active;
  logic [1:0] cnt_pp, q0_pp, cur_pp, ref_dir;

  assign sped_period = ({1'b0, Tick_Period} < SAT_EDGE) ? MIN_P : (Tick_Period - STEP_P);

  // Pop is resolved before the push so a press in the tick cycle is judged
  // against the post-pop tail (or the freshly applied direction).
  always_comb begin
    dir_active = (state == WAIT_TICK) || (state == STEP) || (state == APPLE);
    pop        = (state == WAIT_TICK) && q_Run && (cnt == '0) && (q_cnt != 2'd0);
    cnt_pp     = pop ? (q_cnt - 2'd1) : q_cnt;
    q0_pp      = pop ? q1 : q0;
    cur_pp     = pop ? q0 : Cur_Dirn;
    if (cnt_pp == 2'd0)
      ref_dir = cur_pp;
    else if (cnt_pp == 2'd1)
      ref_dir = q0_pp;
    else
      ref_dir = q1;
    // Same bit[1] covers both a reversal and a repeat of the reference.
    push = SCEN_dir && dir_active && (cnt_pp != 2'd2) && (In_Dirn[1] != ref_dir[1]);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q0       <= 2'b00;
      q1       <= 2'b00;
      q_cnt    <= 2'd0;
      Cur_Dirn <= 2'b11;
    end else if (state == IDLE) begin
      q_cnt <= 2'd0;
    end else begin
      if (pop)
        Cur_Dirn <= q0;
      q_cnt <= cnt_pp + {1'b0, push};
      q0    <= (push && (cnt_pp == 2'd0)) ? In_Dirn : q0_pp;
      q1    <= (push && (cnt_pp == 2'd1)) ? In_Dirn : q1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      Step_Req    <= 1'b0;
      New_Apple   <= 1'b0;
      Hit         <= 1'b0;
      Busy        <= 1'b0;
      Tick_Period <= TICK_INIT;
    end else begin
      New_Apple <= 1'b0;
      Hit       <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (q_Run) begin
            state <= WAIT_TICK;
            cnt   <= Tick_Period - ONE;
          end
        end
        WAIT_TICK: begin
          if (!q_Run) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state    <= STEP;
            Step_Req <= 1'b1;
            Busy     <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        STEP: begin
          if (Step_Done) begin
            Step_Req <= 1'b0;
            if (Collision) begin
              state <= HALT;
              Hit   <= 1'b1;
              Busy  <= 1'b0;
            end else if (Ate_Apple) begin
              state       <= APPLE;
              New_Apple   <= 1'b1;
              Tick_Period <= sped_period;
            end else if (q_Run) begin
              state <= WAIT_TICK;
              Busy  <= 1'b0;
              cnt   <= Tick_Period - ONE;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end
        end
        APPLE: begin
          // Tick_Period was already sped up on entry, so the reload sees it.
          if (Apple_Ready) begin
            Busy <= 1'b0;
            if (q_Run) begin
              state <= WAIT_TICK;
              cnt   <= Tick_Period - ONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALT: begin
          if (!q_Run)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ee354_project_move_sched.sv
`default_nettype none
// =============================================================================
// tb_ee354_project_move_sched : directed checks of the snake move scheduler
// Rev 1.0
// =============================================================================
module tb_ee354_project_move_sched;

  localparam int CNT_W     = 8;
  localparam int APPLE_DLY = 8;

  logic             Clk = 1'b0;
  logic             Reset, q_Run, SCEN_dir;
  logic [1:0]       In_Dirn;
  logic             Step_Done, Collision, Ate_Apple, Apple_Ready;
  logic             Step_Req, New_Apple, Hit, Busy;
  logic [1:0]       Cur_Dirn;
  logic [CNT_W-1:0] Tick_Period;

  int n_checks = 0;
  int n_fail   = 0;

  bit auto_ack     = 1'b1;
  bit req_seen     = 1'b0;
  int apple_wait   = 0;
  int apples_left  = 0;
  int col_left     = 0;
  int apple_seen   = 0;
  int hit_seen     = 0;
  int req_in_apple = 0;

  ee354_project_move_sched #(
    .TICK_DIV  (10),
    .MIN_DIV   (4),
    .SPEED_STEP(3),
    .CNT_W     (CNT_W)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .q_Run      (q_Run),
    .SCEN_dir   (SCEN_dir),
    .In_Dirn    (In_Dirn),
    .Step_Done  (Step_Done),
    .Collision  (Collision),
    .Ate_Apple  (Ate_Apple),
    .Apple_Ready(Apple_Ready),
    .Step_Req   (Step_Req),
    .Cur_Dirn   (Cur_Dirn),
    .New_Apple  (New_Apple),
    .Hit        (Hit),
    .Tick_Period(Tick_Period),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  // Datapath/apple-generator stand-in: acks a step one cycle after the request,
  // answers New_Apple after APPLE_DLY cycles, and tallies pulses.
  initial begin
    Step_Done = 1'b0; Collision = 1'b0; Ate_Apple = 1'b0; Apple_Ready = 1'b0;
    forever begin
      @(negedge Clk);
      Step_Done = auto_ack && (Step_Req === 1'b1) && req_seen;
      Collision = Step_Done && (col_left > 0);
      Ate_Apple = Step_Done && (apples_left > 0);
      if (Collision) col_left--;
      if (Ate_Apple) apples_left--;
      req_seen = (Step_Req === 1'b1);
      if (Hit === 1'b1) hit_seen++;
      if (apple_wait > 0) begin
        apple_wait--;
        if (Step_Req === 1'b1) req_in_apple++;
        Apple_Ready = (apple_wait == 0);
      end else begin
        Apple_Ready = 1'b0;
      end
      if (New_Apple === 1'b1) begin
        apple_seen++;
        apple_wait = APPLE_DLY;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_high(output int n);
    n = 0;
    while (Step_Req !== 1'b1 && n < 200) begin @(negedge Clk); n++; end
    if (n >= 200) check("high_timeout", 32'(n), 32'd0);
  endtask

  // Counts negedges from the current step to the next Step_Req rise.
  task automatic wait_rise(output int n);
    n = 0;
    while (Step_Req === 1'b1 && n < 200) begin @(negedge Clk); n++; end
    while (Step_Req !== 1'b1 && n < 200) begin @(negedge Clk); n++; end
    if (n >= 200) check("rise_timeout", 32'(n), 32'd0);
  endtask

  task automatic press(input logic [1:0] d);
    SCEN_dir = 1'b1;
    In_Dirn  = d;
    @(negedge Clk);
    SCEN_dir = 1'b0;
  endtask

  initial begin
    int n;
    int extra;
    int hs, as;
    Reset = 1'b1; q_Run = 1'b0; SCEN_dir = 1'b0; In_Dirn = 2'b00;
    repeat (3) @(negedge Clk);
    check("rst_step_req", 32'(Step_Req), 32'd0);
    check("rst_new_apple", 32'(New_Apple), 32'd0);
    check("rst_hit", 32'(Hit), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_dir", 32'(Cur_Dirn), 32'd3);
    check("rst_period", 32'(Tick_Period), 32'd10);
    Reset = 1'b0;
    @(negedge Clk);

    // Free-running steps at the initial period
    q_Run = 1'b1;
    wait_high(n);
    check("first_latency", 32'(n), 32'd11);
    check("busy_in_step", 32'(Busy), 32'd1);
    check("dir_default", 32'(Cur_Dirn), 32'd3);
    wait_rise(n); check("period_a", 32'(n), 32'd12);
    wait_rise(n); check("period_b", 32'(n), 32'd12);

    // Equal-axis press dropped, then up and left queued
    press(2'b10); press(2'b00); press(2'b10);
    wait_rise(n); check("t2_dir_up", 32'(Cur_Dirn), 32'd0);
    wait_rise(n); check("t2_dir_left", 32'(Cur_Dirn), 32'd2);

    // Third press into a full queue is dropped
    press(2'b00); press(2'b10); press(2'b01);
    wait_rise(n); check("t3_dir_up", 32'(Cur_Dirn), 32'd0);
    wait_rise(n); check("t3_dir_left", 32'(Cur_Dirn), 32'd2);
    wait_rise(n); check("t3_dir_hold", 32'(Cur_Dirn), 32'd2);

    // Press landing on the pop cycle sees the post-pop tail and fits
    press(2'b00); press(2'b10);
    repeat (9) @(negedge Clk);
    press(2'b00);
    check("popush_req", 32'(Step_Req), 32'd1);
    check("popush_dir0", 32'(Cur_Dirn), 32'd0);
    wait_rise(n); check("popush_dir1", 32'(Cur_Dirn), 32'd2);
    wait_rise(n); check("popush_dir2", 32'(Cur_Dirn), 32'd0);

    // Three apples: period 10 -> 7 -> 4 -> 4, steps wait for Apple_Ready
    as = apple_seen;
    apples_left = 3;
    wait_rise(n); check("apple1_interval", 32'(n), 32'd18);
    check("apple1_period", 32'(Tick_Period), 32'd7);
    wait_rise(n); check("apple2_interval", 32'(n), 32'd15);
    check("apple2_period", 32'(Tick_Period), 32'd4);
    wait_rise(n); check("apple3_interval", 32'(n), 32'd15);
    check("apple3_period", 32'(Tick_Period), 32'd4);
    wait_rise(n); check("post_apple_interval", 32'(n), 32'd6);
    check("apple_pulses", 32'(apple_seen - as), 32'd3);
    check("req_in_apple", 32'(req_in_apple), 32'd0);

    // Collision beats apple: Hit, no New_Apple, halted until q_Run cycles
    hs = hit_seen; as = apple_seen;
    apples_left = 1; col_left = 1;
    repeat (2) @(negedge Clk);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Step_Req === 1'b1) extra++;
    end
    check("halt_no_step", 32'(extra), 32'd0);
    check("hit_pulses", 32'(hit_seen - hs), 32'd1);
    check("col_no_apple", 32'(apple_seen - as), 32'd0);
    check("halt_busy", 32'(Busy), 32'd0);
    q_Run = 1'b0;
    repeat (2) @(negedge Clk);
    q_Run = 1'b1;
    wait_high(n);
    check("resume_latency", 32'(n), 32'd5);
    check("resume_period", 32'(Tick_Period), 32'd4);

    // q_Run blip during WAIT_TICK restarts from IDLE
    repeat (3) @(negedge Clk);
    q_Run = 1'b0;
    @(negedge Clk);
    q_Run = 1'b1;
    wait_high(n);
    check("wait_drop_latency", 32'(n), 32'd5);

    // q_Run dropped mid-STEP: request held until acked, then idle
    auto_ack = 1'b0;
    q_Run = 1'b0;
    repeat (5) @(negedge Clk);
    check("held_req", 32'(Step_Req), 32'd1);
    check("held_busy", 32'(Busy), 32'd1);
    auto_ack = 1'b1;
    repeat (3) @(negedge Clk);
    check("drop_req", 32'(Step_Req), 32'd0);
    check("drop_busy", 32'(Busy), 32'd0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Step_Req === 1'b1) extra++;
    end
    check("idle_no_step", 32'(extra), 32'd0);

    // Reset while waiting in APPLE
    q_Run = 1'b1;
    wait_high(n);
    apples_left = 1;
    repeat (3) @(negedge Clk);
    check("apple_busy", 32'(Busy), 32'd1);
    check("apple_pulse_end", 32'(New_Apple), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    check("rst2_step_req", 32'(Step_Req), 32'd0);
    check("rst2_new_apple", 32'(New_Apple), 32'd0);
    check("rst2_hit", 32'(Hit), 32'd0);
    check("rst2_busy", 32'(Busy), 32'd0);
    check("rst2_dir", 32'(Cur_Dirn), 32'd3);
    check("rst2_period", 32'(Tick_Period), 32'd10);
    Reset = 1'b0;
    q_Run = 1'b0;
    repeat (2) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
